// File: rtl/dmem_arb_pkg.sv
// Shared widths and the port-stage entry type for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 8;
  localparam int DW_DEF   = 8;

  typedef struct packed {
    logic              valid;
    logic [1:0]        id;
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '0;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// 4-way rotating-priority first-one finder: scans ptr, ptr+1, ... mod 4 over
// requests not masked by excl and reports the first hit.
module rr_pick (
  input  logic [3:0] req,
  input  logic [3:0] excl,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx,
  output logic [3:0] onehot
);

  logic [3:0] elig;

  always_comb begin
    elig  = req & ~excl;
    found = 1'b0;
    idx   = 2'd0;
    // Walk from the farthest position back so the nearest eligible one wins.
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr + 2'(k)]) begin
        found = 1'b1;
        idx   = ptr + 2'(k);
      end
    end
    onehot = found ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Four requesters onto two memory ports: round-robin grant of up to two commands
// per cycle, a registered port stage, and a fixed two-cycle read response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic [AW-1:0]      m1_addr,
  output logic [DW-1:0]      m1_wdata,
  output logic               m1_we,
  output logic               m1_re,
  output logic [AW-1:0]      m2_addr,
  output logic [DW-1:0]      m2_wdata,
  output logic               m2_we,
  output logic               m2_re,
  input  logic [DW-1:0]      m1_rdata,
  input  logic [DW-1:0]      m2_rdata,
  output logic [7:0]         conflict_cnt
);

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        conflict_q, conflict_d;
  stage_t            slot1_q, slot1_d, slot2_q, slot2_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [NREQ*DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];

  logic       s1_found, s2_found;
  logic [1:0] s1_idx, s2_idx;
  logic [3:0] s1_gnt, s2_gnt;
  logic [3:0] cmask, excl2;
  logic       conflict_hit;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
    end
  end

  rr_pick u_pick1 (
    .req    (req_valid),
    .excl   (4'b0000),
    .ptr    (rr_ptr_q),
    .found  (s1_found),
    .idx    (s1_idx),
    .onehot (s1_gnt)
  );

  // Two writes to one address in one cycle would race in memory; defer the later one.
  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      cmask[j] = s1_found && req_we[s1_idx] && req_we[j] && (addr_a[j] == addr_a[s1_idx]);
    end
    excl2        = s1_gnt | cmask;
    conflict_hit = |(req_valid & cmask & ~s1_gnt);
  end

  rr_pick u_pick2 (
    .req    (req_valid),
    .excl   (excl2),
    .ptr    (rr_ptr_q),
    .found  (s2_found),
    .idx    (s2_idx),
    .onehot (s2_gnt)
  );

  assign req_gnt = rst_n ? (s1_gnt | s2_gnt) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (s2_found)      rr_ptr_d = s2_idx + 2'd1;
    else if (s1_found) rr_ptr_d = s1_idx + 2'd1;

    conflict_d = conflict_q;
    if (conflict_hit && conflict_q != 8'hFF) conflict_d = conflict_q + 8'd1;

    slot1_d = STAGE_EMPTY;
    if (s1_found) begin
      slot1_d.valid = 1'b1;
      slot1_d.id    = s1_idx;
      slot1_d.we    = req_we[s1_idx];
      slot1_d.addr  = addr_a[s1_idx];
      slot1_d.wdata = wdata_a[s1_idx];
    end
    slot2_d = STAGE_EMPTY;
    if (s2_found) begin
      slot2_d.valid = 1'b1;
      slot2_d.id    = s2_idx;
      slot2_d.we    = req_we[s2_idx];
      slot2_d.addr  = addr_a[s2_idx];
      slot2_d.wdata = wdata_a[s2_idx];
    end

    // Slots always carry distinct requesters, so the two lanes never collide.
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    if (slot1_q.valid && !slot1_q.we) begin
      rsp_valid_d[slot1_q.id]                   = 1'b1;
      rsp_rdata_d[int'(slot1_q.id)*DW +: DW]    = m1_rdata;
    end
    if (slot2_q.valid && !slot2_q.we) begin
      rsp_valid_d[slot2_q.id]                   = 1'b1;
      rsp_rdata_d[int'(slot2_q.id)*DW +: DW]    = m2_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= 2'd0;
      conflict_q  <= 8'd0;
      slot1_q     <= STAGE_EMPTY;
      slot2_q     <= STAGE_EMPTY;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      conflict_q  <= conflict_d;
      slot1_q     <= slot1_d;
      slot2_q     <= slot2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Empty slots hold all-zero fields, so the port drive needs no extra gating.
  assign m1_addr      = slot1_q.addr;
  assign m1_wdata     = slot1_q.wdata;
  assign m1_we        = slot1_q.valid & slot1_q.we;
  assign m1_re        = slot1_q.valid & ~slot1_q.we;
  assign m2_addr      = slot2_q.addr;
  assign m2_wdata     = slot2_q.wdata;
  assign m2_we        = slot2_q.valid & slot2_q.we;
  assign m2_re        = slot2_q.valid & ~slot2_q.we;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign conflict_cnt = conflict_q;

endmodule
